blowfish_block_sequencer: RTL and testbench

- Sits around the 128-bit dual-core Blowfish block.
- Upstream side: packs a 32-bit valid/ready word stream into a 128-bit plaintext/ciphertext block and drives the core's pt and mode inputs, holding them stable.
- Waits a fixed core latency, then captures the core's 128-bit ct.
- Downstream side: presents the captured ct on a valid/ready result port. One block is in flight at a time.

---
 rtl/blowfish_pkg.sv | 16 +
 rtl/blowfish_word_packer.sv | 43 ++++
 rtl/blowfish_block_sequencer.sv | 82 ++++++++
 tb/tb_blowfish_block_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish_pkg.sv
// Shared widths, mode encoding and sequencer state encoding for the
// Blowfish block sequencer.
package blowfish_pkg;
   localparam int BLK_W         = 128;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_BLK = 4;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } seq_state_e;
endpackage

// File: rtl/blowfish_word_packer.sv
// Packs accepted 32-bit words into the 128-bit core block, most significant
// slot first, zero-padding the tail of short blocks. Latches the mode with
// the first word and flags the accept that closes the block.
module blowfish_word_packer
   import blowfish_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic              clear,
   input  logic [WORD_W-1:0] data,
   input  logic              last,
   input  logic              mode_in,
   output logic [BLK_W-1:0]  pt,
   output logic              mode,
   output logic              block_closed
);
   logic [1:0] idx;

   // Block ends on the fourth word or on an early in_last, whichever is first.
   assign block_closed = accept && ((idx == 2'd3) || last);

   // Slot write, tail zeroing, mode latch and word index.
   always_ff @(posedge clk) begin
      if (rst) begin
         pt   <= '0;
         mode <= MODE_ENC;
         idx  <= 2'd0;
      end else if (clear) begin
         pt <= '0;
      end else if (accept) begin
         if (idx == 2'd0)
            mode <= mode_in;
         for (int s = 0; s < WORDS_PER_BLK; s++) begin
            if (s == int'(idx))
               pt[BLK_W-1-s*WORD_W -: WORD_W] <= data;
            else if (last && (s > int'(idx)))
               pt[BLK_W-1-s*WORD_W -: WORD_W] <= '0;
         end
         idx <= block_closed ? 2'd0 : idx + 2'd1;
      end
   end
endmodule

// File: rtl/blowfish_block_sequencer.sv
// Feeds one block at a time into the Blowfish core: fills pt from a word
// stream, waits the fixed core latency, then offers the captured ct on a
// valid/ready result port until it is taken.
module blowfish_block_sequencer
   import blowfish_pkg::*;
#(
   parameter int CORE_LAT = 17,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   input  logic              in_mode,
   output logic              in_ready,
   output logic [BLK_W-1:0]  pt,
   output logic              mode,
   input  logic [BLK_W-1:0]  ct,
   output logic [BLK_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   seq_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             accept, closed, lat_done, handshake;

   assign in_ready  = (state == FILL);
   assign accept    = in_valid && in_ready;
   assign lat_done  = (state == WAIT) && (cnt == CNT_W'(CORE_LAT - 1));
   assign handshake = (state == HOLD) && out_valid && out_ready;

   blowfish_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .accept       (accept),
      .clear        (handshake),
      .data         (in_data),
      .last         (in_last),
      .mode_in      (in_mode),
      .pt           (pt),
      .mode         (mode),
      .block_closed (closed)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nx;
   end

   // Next state: fill -> wait out the core latency -> hold result -> fill.
   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (closed)    state_nx = WAIT;
         WAIT:    if (lat_done)  state_nx = HOLD;
         HOLD:    if (handshake) state_nx = FILL;
         default:                state_nx = FILL;
      endcase
   end

   // Latency counter: starts at 0 on the close edge, counts every WAIT cycle.
   always_ff @(posedge clk) begin
      if (rst)                 cnt <= '0;
      else if (closed)         cnt <= '0;
      else if (state == WAIT)  cnt <= cnt + 1'b1;
   end

   // Result register: capture ct when the latency expires; data outlives valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (lat_done) begin
         out_data  <= ct;
         out_valid <= 1'b1;
      end else if (handshake) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_blowfish_block_sequencer.sv
// Bench for blowfish_block_sequencer: a stand-in core with the same latency,
// a transaction-level reference model compared every cycle, a result
// scoreboard, and directed plus randomized block traffic.
module tb_blowfish_block_sequencer;
   localparam int L = 17;
   localparam logic [127:0] KEY = 128'h5A5A_1234_F0F0_9876_0FED_CBA9_8765_4321;

   logic         clk = 1'b0, rst = 1'b1;
   logic [31:0]  in_data = '0;
   logic         in_valid = 1'b0, in_last = 1'b0, in_mode = 1'b0;
   logic         in_ready;
   logic [127:0] pt, ct, out_data;
   logic         mode, out_valid;
   logic         out_ready = 1'b0;

   int checks = 0, errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   blowfish_block_sequencer #(.CORE_LAT(L), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_mode(in_mode), .in_ready(in_ready),
      .pt(pt), .mode(mode), .ct(ct), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   // Toy invertible cipher: rotate-left-13 then xor key; decrypt reverses it.
   function automatic logic [127:0] core_f(input logic [127:0] x, input logic m);
      logic [127:0] z;
      if (!m) return {x[114:0], x[127:115]} ^ KEY;
      z = x ^ KEY;
      return {z[12:0], z[127:13]};
   endfunction

   // Stand-in core: L-1 register stages so ct is valid L cycles after pt settles.
   logic [127:0] cpipe [0:L-2];
   always @(posedge clk) begin
      cpipe[0] <= core_f(pt, mode);
      for (int i = 1; i <= L-2; i++) cpipe[i] <= cpipe[i-1];
   end
   assign ct = cpipe[L-2];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: block being filled, remaining wait, pending result.
   bit           m_init = 0, m_ready = 1, m_ov = 0, m_mode = 0;
   int           m_n = 0, m_wait = 0;
   logic [127:0] m_pt = '0, m_odata = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_init = 1; m_ready = 1; m_ov = 0; m_mode = 0;
         m_n = 0; m_wait = 0; m_pt = '0; m_odata = '0;
      end else if (m_ready) begin
         if (in_valid) begin
            if (m_n == 0) m_mode = in_mode;
            m_pt[127-32*m_n -: 32] = in_data;
            if (m_n == 3 || in_last) begin
               for (int k = m_n + 1; k < 4; k++) m_pt[127-32*k -: 32] = '0;
               m_n = 0; m_ready = 0; m_wait = L;
            end else begin
               m_n++;
            end
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_ov = 1;
            m_odata = core_f(m_pt, m_mode);
         end
      end else if (m_ov && out_ready) begin
         m_ov = 0; m_ready = 1; m_pt = '0;
      end
   end

   // Per-cycle compare, result scoreboard and out_valid rise timestamps.
   logic [127:0] sb_q[$];
   int           rises[$];
   bit           ov_prev = 0;
   always @(negedge clk) begin
      if (m_init) begin
         chk("in_ready", 128'(in_ready), 128'(m_ready));
         chk("pt", pt, m_pt);
         chk("mode", 128'(mode), 128'(m_mode));
         chk("out_valid", 128'(out_valid), 128'(m_ov));
         chk("out_data", out_data, m_odata);
         if (out_valid && out_ready && !rst) begin
            if (sb_q.size() == 0) chk("sb_unexpected", out_data, 128'hx);
            else                  chk("scoreboard", out_data, sb_q.pop_front());
         end
         if (out_valid && !ov_prev) rises.push_back(cyc);
         ov_prev = out_valid;
      end
   end

   bit rand_or = 0;
   always @(posedge clk) if (rand_or) begin #1; out_ready = 1'($urandom % 2); end

   task automatic send_word(input logic [31:0] d, input logic l, input logic m);
      bit ok = 0;
      in_valid = 1; in_data = d; in_last = l; in_mode = m;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (ok) begin @(posedge clk); #1; end
      else chk("send_timeout", 0, 1);
      in_valid = 0; in_last = 0;
   endtask

   task automatic send_block(input logic [127:0] blk, input int n, input logic mf,
                             input logic ml, input logic last4, input bit gaps);
      logic [127:0] e = '0;
      for (int i = 0; i < n; i++) e[127-32*i -: 32] = blk[127-32*i -: 32];
      sb_q.push_back(core_f(e, mf));
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom % 3) begin @(posedge clk); #1; end
         send_word(blk[127-32*i -: 32], (i == n-1) && (n < 4 || last4), (i == 0) ? mf : ml);
      end
   endtask

   // Counts cycles from now until out_valid is seen high just after an edge.
   task automatic wait_valid(output int n);
      n = 0;
      for (int t = 0; t < 600; t++) begin
         @(posedge clk); #1; n++;
         if (out_valid) return;
      end
      chk("valid_timeout", 0, 1);
   endtask

   task automatic do_reset(input string nm);
      rst = 1; @(posedge clk); #1; rst = 0;
      sb_q.delete();
      chk({nm, "_pt"}, pt, 128'h0);
      chk({nm, "_ov"}, 128'(out_valid), 128'h0);
      chk({nm, "_rdy"}, 128'(in_ready), 128'h1);
   endtask

   initial begin
      int n;
      logic [127:0] orig, saved;
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [127:0] orig, saved;
      repeat (2) @(posedge clk);
      #1;
      do_reset("reset");

      // Full block, in_valid held high.
      out_ready = 1;
      send_block(128'h0123456789ABCDEFFEDCBA9876543210, 4, 0, 0, 0, 0);
      chk("full_pt", pt, 128'h0123456789ABCDEFFEDCBA9876543210);
      chk("full_mode", 128'(mode), 128'h0);
      wait_valid(n);
      chk("full_lat", 128'(n), 128'(L));
      @(posedge clk); #1;

      // Short block with zero padding.
      send_block(128'hDEADBEEFCAFEF00D0000000000000000, 2, 0, 0, 0, 0);
      chk("short_pt", pt, 128'hDEADBEEFCAFEF00D0000000000000000);
      wait_valid(n);
      chk("short_lat", 128'(n), 128'(L));
      @(posedge clk); #1;

      // Mode latched from first word; decrypt round-trip.
      orig = 128'h00112233445566778899AABBCCDDEEFF;
      send_block(core_f(orig, 0), 4, 1, 0, 1, 0);
      chk("latch_mode", 128'(mode), 128'h1);
      wait_valid(n);
      chk("decrypt_roundtrip", out_data, 128'h00112233445566778899AABBCCDDEEFF);
      @(posedge clk); #1;

      // Backpressure: result held, stray words ignored.
      out_ready = 0;
      send_block(128'hA5A5A5A5_5A5A5A5A_11111111_22222222, 4, 0, 0, 0, 0);
      wait_valid(n);
      saved = out_data;
      for (int i = 0; i < 50; i++) begin
         in_valid = 1; in_data = $urandom; in_last = 1'($urandom % 2);
         @(posedge clk); #1;
         chk("bp_data", out_data, saved);
         chk("bp_rdy", 128'(in_ready), 128'h0);
      end
      in_valid = 0; in_last = 0; out_ready = 1;
      @(posedge clk); #1;
      chk("bp_release_rdy", 128'(in_ready), 128'h1);
      chk("bp_release_ov", 128'(out_valid), 128'h0);
      chk("bp_keep_data", out_data, saved);

      // Reset in FILL (idx=2), WAIT (counter=5), HOLD.
      send_word(32'h11112222, 0, 1);
      send_word(32'h33334444, 0, 0);
      do_reset("rst_fill");
      send_block(128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 4, 0, 0, 0, 0);
      repeat (5) begin @(posedge clk); #1; end
      do_reset("rst_wait");
      out_ready = 0;
      send_block(128'hCAFEBABE_DEADBEEF_01010101_20202020, 4, 1, 1, 0, 0);
      wait_valid(n);
      do_reset("rst_hold");
      out_ready = 1;
      send_block(128'h0123456789ABCDEFFEDCBA9876543210, 4, 0, 0, 0, 0);
      wait_valid(n);
      chk("post_rst_lat", 128'(n), 128'(L));
      chk("post_rst_data", out_data, core_f(128'h0123456789ABCDEFFEDCBA9876543210, 0));
      @(posedge clk); #1;

      // Back-to-back, out_ready tied high.
      rises.delete();
      for (int b = 0; b < 3; b++)
         send_block({$urandom, $urandom, $urandom, $urandom}, 4, 1'(b % 2), 0, 0, 0);
      for (int t = 0; t < 200 && rises.size() < 3; t++) begin @(posedge clk); #1; end
      chk("b2b_count", 128'(rises.size()), 128'h3);
      if (rises.size() >= 3) begin
         chk("b2b_gap0", 128'(rises[1] - rises[0]), 128'(L + 5));
         chk("b2b_gap1", 128'(rises[2] - rises[1]), 128'(L + 5));
      end
      @(posedge clk); #1;

      // Randomized traffic with random result backpressure.
      rand_or = 1;
      for (int b = 0; b < 40; b++)
         send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 4),
                    1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1);
      rand_or = 0;
      @(posedge clk); #2;
      out_ready = 1;
      for (int t = 0; t < 200 && !(in_ready && !out_valid); t++) begin @(posedge clk); #1; end
      chk("drain_idle", 128'(in_ready && !out_valid), 128'h1);
      chk("sb_drained", 128'(sb_q.size()), 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
